turn_move_sequencer: RTL and testbench

Sequences one player move end to end: checks ownership, runs the shared piece evaluator, writes the move to the board, runs the check-all scan, and either commits the move or reverts it. It sits between the cursor/input logic and the board register file, the piece evaluator and the check-all controller. It owns the side-to-move flag.

---
 rtl/turn_move_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_turn_move_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_move_sequencer.sv
// Sequences one player move: ownership check, evaluator run, board write, check-all scan,
// then commit or revert. Optional pawn auto-promotion on the last rank under AUTO_PROMOTE_EN.
module turn_move_sequencer #(
  parameter int unsigned WAIT_LIMIT = 4095,
  parameter int unsigned WAIT_W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         moveReq,
  input  logic [5:0]   moveFrom,
  input  logic [5:0]   moveTo,
  input  logic [255:0] boardData,
  output logic         boardWrite,
  output logic [5:0]   writeAddr,
  output logic [3:0]   writeData,
  output logic [5:0]   evalPosition,
  output logic         evalStart,
  input  logic         evalDone,
  input  logic [63:0]  evalMoves,
  output logic         updateAll,
  input  logic         checkAllReady,
  input  logic [1:0]   checkIn,
  output logic         turn,
  output logic         busy,
  output logic         moveAccepted,
  output logic         moveRejected,
  output logic [1:0]   rejectCode
);

  localparam logic [3:0] StIdle       = 4'd0;
  localparam logic [3:0] StValidate   = 4'd1;
  localparam logic [3:0] StEvalStart  = 4'd2;
  localparam logic [3:0] StEvalWait   = 4'd3;
  localparam logic [3:0] StWriteTo    = 4'd4;
  localparam logic [3:0] StWriteFrom  = 4'd5;
  localparam logic [3:0] StCheckStart = 4'd6;
  localparam logic [3:0] StCheckBusy  = 4'd7;
  localparam logic [3:0] StCheckDone  = 4'd8;
  localparam logic [3:0] StDecide     = 4'd9;
  localparam logic [3:0] StRevertFrom = 4'd10;
  localparam logic [3:0] StRevertTo   = 4'd11;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        from_q, from_d, to_q, to_d;
  logic [3:0]        src_q, src_d, dst_q, dst_d;
  logic [1:0]        chk_q, chk_d;
  logic [1:0]        rev_code_q, rev_code_d;
  logic [1:0]        code_q, code_d;
  logic              turn_q, turn_d;
  logic              acc_q, acc_d, rej_q, rej_d;
  logic              wait_hit;
  logic [3:0]        to_code;

`ifdef AUTO_PROMOTE_EN
  logic promote;
  assign promote = (src_q[2:0] == 3'd1) &&
                   (src_q[3] ? (to_q[5:3] == 3'd0) : (to_q[5:3] == 3'd7));
  assign to_code = promote ? {src_q[3], 3'd5} : src_q;
`else
  assign to_code = src_q;
`endif

  assign wait_hit = (wait_q == WAIT_W'(WAIT_LIMIT));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    from_d     = from_q;
    to_d       = to_q;
    src_d      = src_q;
    dst_d      = dst_q;
    chk_d      = chk_q;
    rev_code_d = rev_code_q;
    code_d     = code_q;
    turn_d     = turn_q;
    acc_d      = 1'b0;
    rej_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (moveReq) begin
          from_d  = moveFrom;
          to_d    = moveTo;
          src_d   = boardData[{moveFrom, 2'b00} +: 4];
          dst_d   = boardData[{moveTo, 2'b00} +: 4];
          state_d = StValidate;
        end
      end
      StValidate: begin
        if (src_q == 4'd0 || src_q[3] != turn_q) begin
          rej_d   = 1'b1;
          code_d  = 2'd0;
          state_d = StIdle;
        end else if (from_q == to_q || (dst_q != 4'd0 && dst_q[3] == turn_q)) begin
          rej_d   = 1'b1;
          code_d  = 2'd1;
          state_d = StIdle;
        end else begin
          state_d = StEvalStart;
        end
      end
      StEvalStart: begin
        wait_d  = '0;
        state_d = StEvalWait;
      end
      StEvalWait: begin
        if (evalDone) begin
          if (evalMoves[to_q]) begin
            state_d = StWriteTo;
          end else begin
            rej_d   = 1'b1;
            code_d  = 2'd1;
            state_d = StIdle;
          end
        end else if (wait_hit) begin
          rej_d   = 1'b1;
          code_d  = 2'd3;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWriteTo:    state_d = StWriteFrom;
      StWriteFrom:  state_d = StCheckStart;
      StCheckStart: begin
        wait_d  = '0;
        state_d = StCheckBusy;
      end
      StCheckBusy: begin
        if (!checkAllReady) begin
          wait_d  = '0;
          state_d = StCheckDone;
        end else if (wait_hit) begin
          rev_code_d = 2'd3;
          state_d    = StRevertFrom;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheckDone: begin
        if (checkAllReady) begin
          chk_d   = checkIn;
          state_d = StDecide;
        end else if (wait_hit) begin
          rev_code_d = 2'd3;
          state_d    = StRevertFrom;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecide: begin
        if (chk_q[turn_q]) begin
          rev_code_d = 2'd2;
          state_d    = StRevertFrom;
        end else begin
          acc_d   = 1'b1;
          turn_d  = ~turn_q;
          state_d = StIdle;
        end
      end
      StRevertFrom: state_d = StRevertTo;
      StRevertTo: begin
        rej_d   = 1'b1;
        code_d  = rev_code_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      from_q     <= '0;
      to_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      chk_q      <= '0;
      rev_code_q <= '0;
      code_q     <= '0;
      turn_q     <= 1'b0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      from_q     <= from_d;
      to_q       <= to_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      chk_q      <= chk_d;
      rev_code_q <= rev_code_d;
      code_q     <= code_d;
      turn_q     <= turn_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
    end
  end

  // Strobes decode straight from state so IDLE (and reset) drives them all low.
  always_comb begin
    boardWrite = 1'b0;
    writeAddr  = 6'd0;
    writeData  = 4'd0;
    case (state_q)
      StWriteTo: begin
        boardWrite = 1'b1;
        writeAddr  = to_q;
        writeData  = to_code;
      end
      StWriteFrom: begin
        boardWrite = 1'b1;
        writeAddr  = from_q;
      end
      StRevertFrom: begin
        boardWrite = 1'b1;
        writeAddr  = from_q;
        writeData  = src_q;
      end
      StRevertTo: begin
        boardWrite = 1'b1;
        writeAddr  = to_q;
        writeData  = dst_q;
      end
      default: ;
    endcase
  end

  assign evalStart    = (state_q == StEvalStart);
  assign evalPosition = (state_q == StEvalStart || state_q == StEvalWait) ? from_q : 6'd0;
  assign updateAll    = (state_q == StCheckStart);
  assign busy         = (state_q != StIdle);
  assign turn         = turn_q;
  assign moveAccepted = acc_q;
  assign moveRejected = rej_q;
  assign rejectCode   = code_q;

endmodule

// File: tb/tb_turn_move_sequencer.sv
// Directed bench for turn_move_sequencer with small evaluator, check-all and board models.
module tb_turn_move_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         moveReq = 1'b0;
  logic [5:0]   moveFrom = '0, moveTo = '0;
  logic [255:0] board = '0;
  logic         boardWrite;
  logic [5:0]   writeAddr;
  logic [3:0]   writeData;
  logic [5:0]   evalPosition;
  logic         evalStart;
  logic         eval_done = 1'b0;
  logic [63:0]  eval_bm = '0;
  logic         updateAll;
  logic         ck_ready = 1'b1;
  logic [1:0]   chk_val = 2'b00;
  logic         turn, busy, moveAccepted, moveRejected;
  logic [1:0]   rejectCode;

  always #5 clk = ~clk;

  turn_move_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .moveReq      (moveReq),
    .moveFrom     (moveFrom),
    .moveTo       (moveTo),
    .boardData    (board),
    .boardWrite   (boardWrite),
    .writeAddr    (writeAddr),
    .writeData    (writeData),
    .evalPosition (evalPosition),
    .evalStart    (evalStart),
    .evalDone     (eval_done),
    .evalMoves    (eval_bm),
    .updateAll    (updateAll),
    .checkAllReady(ck_ready),
    .checkIn      (chk_val),
    .turn         (turn),
    .busy         (busy),
    .moveAccepted (moveAccepted),
    .moveRejected (moveRejected),
    .rejectCode   (rejectCode)
  );

  // Board register file, with a bench-side full-board load port.
  logic         ld_all = 1'b0;
  logic [255:0] ld_board = '0;
  always @(posedge clk) begin
    if (ld_all) board <= ld_board;
    else if (boardWrite) board[{writeAddr, 2'b00} +: 4] <= writeData;
  end

  // Evaluator: done two cycles after start unless told to hang.
  logic eval_hang = 1'b0, ck_stuck = 1'b0;
  int   ev_delay = 0, ck_delay = 0;
  always @(posedge clk) begin
    if (evalStart) begin
      eval_done <= 1'b0;
      ev_delay  <= 2;
    end else if (ev_delay > 0) begin
      ev_delay <= ev_delay - 1;
      if (ev_delay == 1 && !eval_hang) eval_done <= 1'b1;
    end
  end

  // Check-all controller: busy for three cycles after updateAll unless stuck idle.
  always @(posedge clk) begin
    if (updateAll) begin
      ck_ready <= ck_stuck;
      ck_delay <= 3;
    end else if (ck_delay > 0) begin
      ck_delay <= ck_delay - 1;
      if (ck_delay == 1) ck_ready <= 1'b1;
    end
  end

  logic       clr = 1'b0;
  int         wr_cnt = 0, ev_cnt = 0, acc_cnt = 0, rej_cnt = 0;
  logic [1:0] last_code = '0;
  always @(posedge clk) begin
    if (clr) begin
      wr_cnt <= 0; ev_cnt <= 0; acc_cnt <= 0; rej_cnt <= 0;
    end else begin
      if (boardWrite)   wr_cnt  <= wr_cnt + 1;
      if (evalStart)    ev_cnt  <= ev_cnt + 1;
      if (moveAccepted) acc_cnt <= acc_cnt + 1;
      if (moveRejected) begin
        rej_cnt   <= rej_cnt + 1;
        last_code <= rejectCode;
      end
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sq(input int s);
    return board[4*s +: 4];
  endfunction

  task automatic load_board(input logic [255:0] b);
    @(negedge clk);
    ld_board = b;
    ld_all   = 1'b1;
    @(negedge clk);
    ld_all   = 1'b0;
  endtask

  task automatic run_move(input logic [5:0] f, input logic [5:0] t, input int budget);
    logic done;
    @(negedge clk);
    clr = 1'b1; moveFrom = f; moveTo = t; moveReq = 1'b1;
    @(negedge clk);
    clr = 1'b0; moveReq = 1'b0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (acc_cnt + rej_cnt > 0) done = 1'b1;
    end
    check("move_completes_in_budget", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0]  from;
    logic [5:0]  to;
    logic [63:0] bm;
    logic [1:0]  chk;
    logic        acc;
    logic [1:0]  code;
    logic        turn_after;
    logic [3:0]  to_sq;
    logic [3:0]  from_sq;
    int          writes;
    int          evals;
  } vec_t;

  vec_t vecs[11];

  localparam logic [63:0] B19 = 64'd1 << 19;
  localparam logic [63:0] B27 = 64'd1 << 27;
  localparam logic [63:0] B28 = 64'd1 << 28;
  localparam logic [63:0] B29 = 64'd1 << 29;
  localparam logic [63:0] B36 = 64'd1 << 36;
  localparam logic [63:0] B60 = 64'd1 << 60;

  initial begin
    logic [255:0] b;
    logic [3:0]   back[8];
    logic [3:0]   promo_exp;
    //        from to  bitmap chk  acc code turn to_sq from_sq wr ev
    vecs[0]  = '{6'd12, 6'd28, B28, 2'b00, 1'b1, 2'd0, 1'b1, 4'h1, 4'h0, 2, 1};
    vecs[1]  = '{6'd28, 6'd36, B36, 2'b00, 1'b0, 2'd0, 1'b1, 4'h0, 4'h1, 0, 0};
    vecs[2]  = '{6'd52, 6'd36, B36, 2'b00, 1'b1, 2'd0, 1'b0, 4'h9, 4'h0, 2, 1};
    vecs[3]  = '{6'd20, 6'd28, B28, 2'b00, 1'b0, 2'd0, 1'b0, 4'h1, 4'h0, 0, 0};
    vecs[4]  = '{6'd11, 6'd11, B27, 2'b00, 1'b0, 2'd1, 1'b0, 4'h1, 4'h1, 0, 0};
    vecs[5]  = '{6'd3,  6'd11, B27, 2'b00, 1'b0, 2'd1, 1'b0, 4'h1, 4'h5, 0, 0};
    vecs[6]  = '{6'd11, 6'd27, B19, 2'b00, 1'b0, 2'd1, 1'b0, 4'h0, 4'h1, 0, 1};
    vecs[7]  = '{6'd11, 6'd27, B27, 2'b01, 1'b0, 2'd2, 1'b0, 4'h0, 4'h1, 4, 1};
    vecs[8]  = '{6'd11, 6'd27, B27, 2'b10, 1'b1, 2'd0, 1'b1, 4'h1, 4'h0, 2, 1};
    vecs[9]  = '{6'd36, 6'd27, B27, 2'b10, 1'b0, 2'd2, 1'b1, 4'h1, 4'h9, 4, 1};
    vecs[10] = '{6'd36, 6'd27, B27, 2'b01, 1'b1, 2'd0, 1'b0, 4'h9, 4'h0, 2, 1};

    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4]      = back[i];
      b[4*(8+i) +: 4]  = 4'h1;
      b[4*(48+i) +: 4] = 4'h9;
      b[4*(56+i) +: 4] = back[i] | 4'h8;
    end

    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_turn", 64'(turn), 64'd0);
    check("reset_code", 64'(rejectCode), 64'd0);
    check("reset_write", 64'(boardWrite), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    load_board(b);

    for (int v = 0; v < 11; v++) begin
      eval_bm = vecs[v].bm;
      chk_val = vecs[v].chk;
      run_move(vecs[v].from, vecs[v].to, 200);
      check($sformatf("v%0d_accepted", v), 64'(acc_cnt), 64'(vecs[v].acc));
      check($sformatf("v%0d_rejected", v), 64'(rej_cnt), 64'(!vecs[v].acc));
      if (!vecs[v].acc) check($sformatf("v%0d_code", v), 64'(last_code), 64'(vecs[v].code));
      check($sformatf("v%0d_turn", v), 64'(turn), 64'(vecs[v].turn_after));
      check($sformatf("v%0d_to_sq", v), 64'(sq(vecs[v].to)), 64'(vecs[v].to_sq));
      check($sformatf("v%0d_from_sq", v), 64'(sq(vecs[v].from)), 64'(vecs[v].from_sq));
      check($sformatf("v%0d_writes", v), 64'(wr_cnt), 64'(vecs[v].writes));
      check($sformatf("v%0d_evals", v), 64'(ev_cnt), 64'(vecs[v].evals));
      check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
    end

    // Check-all never leaves idle: timeout after the board write, so revert first.
    ck_stuck = 1'b1; eval_bm = B29; chk_val = 2'b00;
    run_move(6'd13, 6'd29, 6000);
    check("ck_to_rejected", 64'(rej_cnt), 64'd1);
    check("ck_to_code", 64'(last_code), 64'd3);
    check("ck_to_writes", 64'(wr_cnt), 64'd4);
    check("ck_to_from_sq", 64'(sq(13)), 64'h1);
    check("ck_to_to_sq", 64'(sq(29)), 64'h0);
    check("ck_to_turn", 64'(turn), 64'd0);
    ck_stuck = 1'b0;

    // Evaluator hangs: timeout before any write.
    eval_hang = 1'b1;
    run_move(6'd13, 6'd29, 6000);
    check("ev_to_code", 64'(last_code), 64'd3);
    check("ev_to_writes", 64'(wr_cnt), 64'd0);
    check("ev_to_evals", 64'(ev_cnt), 64'd1);

    // Reset in the middle of an evaluator wait clears every output at once.
    @(negedge clk);
    moveFrom = 6'd13; moveTo = 6'd29; moveReq = 1'b1;
    @(negedge clk);
    moveReq = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before_reset", 64'(busy), 64'd1);
    check("mid_evalpos_before_reset", 64'(evalPosition), 64'd13);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_evalpos", 64'(evalPosition), 64'd0);
    check("mid_reset_code", 64'(rejectCode), 64'd0);
    check("mid_reset_strobes",
          64'({boardWrite, evalStart, updateAll, moveAccepted, moveRejected, turn}), 64'd0);
    check("mid_reset_wr_bus", 64'({writeAddr, writeData}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    eval_hang = 1'b0;

    // White pawn onto rank 8.
    b = board;
    b[4*52 +: 4] = 4'h1;
    b[4*60 +: 4] = 4'h0;
    load_board(b);
    eval_bm = B60; chk_val = 2'b00;
`ifdef AUTO_PROMOTE_EN
    promo_exp = 4'h5;
`else
    promo_exp = 4'h1;
`endif
    run_move(6'd52, 6'd60, 200);
    check("promo_accepted", 64'(acc_cnt), 64'd1);
    check("promo_to_sq", 64'(sq(60)), 64'(promo_exp));
    check("promo_from_sq", 64'(sq(52)), 64'h0);
    check("promo_turn", 64'(turn), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
